player_input_ctrl: RTL and testbench

PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

---
 rtl/space_inv_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/player_input_ctrl.sv | 178 +++++++++++++++++
 tb/tb_player_input_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/space_inv_pkg.sv
// Shared types and constants for the player input block.
// The fire FSM states and missile slot count live here so every stage agrees.
package space_inv_pkg;

    localparam int SCREEN_W     = 640;
    localparam int PLAYER_W     = 16;
    localparam int NUM_MISSILES = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        COOLDOWN = 2'd2
    } fire_state_t;

    // One-hot of the lowest clear bit of busy; all-zero when every slot is taken.
    function automatic logic [NUM_MISSILES-1:0] lowest_free_slot(
        input logic [NUM_MISSILES-1:0] busy
    );
        logic [NUM_MISSILES-1:0] inc;
        inc = busy + {{(NUM_MISSILES-1){1'b0}}, 1'b1};
        return ~busy & inc;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output follows the
// synchronized input only after it has disagreed for DEBOUNCE_CYCLES straight cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 315000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the input agrees with the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = level_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Player controls: debounced buttons drive a saturating sprite column and a
// fire FSM that launches one missile per debounced fire press.
module player_input_ctrl
    import space_inv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 315000,
    parameter int MOVE_TICKS      = 500000,
    parameter int MOVE_STEP       = 2,
    parameter int FIRE_COOLDOWN   = 4000000,
    parameter int COL_INIT        = 312,
    parameter int COL_MAX         = SCREEN_W - PLAYER_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_fire,
    input  logic [7:0]  missile_busy,
    output logic [11:0] btn_col,
    output logic [7:0]  btn_missle_en,
    output logic        fire_pulse,
    output logic        fire_dropped
);

    localparam int TICK_W = $clog2(MOVE_TICKS + 1);
    localparam int CD_W   = $clog2(FIRE_COOLDOWN + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVE_TICKS - 1);
    localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(FIRE_COOLDOWN - 1);
    localparam logic [11:0]       STEP      = 12'(MOVE_STEP);
    localparam logic [11:0]       MAX_COL   = 12'(COL_MAX);
    localparam logic [11:0]       INIT_COL  = 12'(COL_INIT);

    logic left_db;
    logic right_db;
    logic fire_db;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_left),
        .btn_db  (left_db)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_right),
        .btn_db  (right_db)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_fire),
        .btn_db  (fire_db)
    );

    logic              only_left;
    logic              only_right;
    logic              move_tick;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic [11:0]       col_q;
    logic [11:0]       col_d;

    // The tick counter idles at zero unless exactly one direction is held,
    // so the first step always lands a full MOVE_TICKS after the press.
    always_comb begin
        only_left  = left_db & ~right_db;
        only_right = right_db & ~left_db;
        tick_cnt_d = '0;
        move_tick  = 1'b0;
        if (only_left || only_right) begin
            if (tick_cnt_q == TICK_LAST) begin
                move_tick = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end

        col_d = col_q;
        if (move_tick && only_left) begin
            col_d = (col_q < STEP) ? 12'd0 : col_q - STEP;
        end else if (move_tick && only_right) begin
            col_d = (col_q > MAX_COL - STEP) ? MAX_COL : col_q + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            col_q      <= INIT_COL;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            col_q      <= col_d;
        end
    end

    fire_state_t      state_q;
    fire_state_t      state_d;
    logic [CD_W-1:0]  cd_cnt_q;
    logic [CD_W-1:0]  cd_cnt_d;
    logic [7:0]       en_q;
    logic [7:0]       en_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             dropped_q;
    logic             dropped_d;
    logic             fire_prev_q;
    logic             fire_edge;
    logic [7:0]       free_slot;

    // fire_prev_q tracks the debounced level in every state, so edges seen
    // outside IDLE are simply lost rather than remembered.
    always_comb begin
        fire_edge = fire_db & ~fire_prev_q;
        free_slot = lowest_free_slot(missile_busy);
        state_d   = state_q;
        cd_cnt_d  = cd_cnt_q;
        en_d      = en_q;
        pulse_d   = 1'b0;
        dropped_d = 1'b0;
        case (state_q)
            IDLE: begin
                cd_cnt_d = '0;
                if (fire_edge) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d  = COOLDOWN;
                cd_cnt_d = '0;
                if (free_slot != 8'd0) begin
                    en_d    = en_q ^ free_slot;
                    pulse_d = 1'b1;
                end else begin
                    dropped_d = 1'b1;
                end
            end
            COOLDOWN: begin
                if (cd_cnt_q == CD_LAST) begin
                    state_d  = IDLE;
                    cd_cnt_d = '0;
                end else begin
                    cd_cnt_d = cd_cnt_q + CD_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                cd_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cd_cnt_q    <= '0;
            en_q        <= 8'd0;
            pulse_q     <= 1'b0;
            dropped_q   <= 1'b0;
            fire_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cd_cnt_q    <= cd_cnt_d;
            en_q        <= en_d;
            pulse_q     <= pulse_d;
            dropped_q   <= dropped_d;
            fire_prev_q <= fire_db;
        end
    end

    assign btn_col       = col_q;
    assign btn_missle_en = en_q;
    assign fire_pulse    = pulse_q;
    assign fire_dropped  = dropped_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Randomized scoreboard bench for player_input_ctrl: stimulus pushes expected
// column steps and fire events, a negedge monitor pops and compares them.
module tb_player_input_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_fire = 1'b0;
    logic [7:0]  missile_busy = 8'd0;
    logic [11:0] btn_col;
    logic [7:0]  btn_missle_en;
    logic        fire_pulse;
    logic        fire_dropped;

    always #5 clk = ~clk;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .MOVE_TICKS      (8),
        .MOVE_STEP       (2),
        .FIRE_COOLDOWN   (16),
        .COL_INIT        (312),
        .COL_MAX         (624)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_fire      (btn_fire),
        .missile_busy  (missile_busy),
        .btn_col       (btn_col),
        .btn_missle_en (btn_missle_en),
        .fire_pulse    (fire_pulse),
        .fire_dropped  (fire_dropped)
    );

    typedef struct packed {
        logic       dropped;
        logic [7:0] en;
    } fire_ev_t;

    int       col_q[$];
    fire_ev_t fire_q[$];
    int       errors = 0;
    int       checks = 0;
    int       model_col = 312;
    logic [7:0] model_en = 8'd0;
    logic [11:0] last_col = 12'd312;
    logic [7:0]  last_en = 8'd0;
    fire_ev_t    mon_ev;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A fire press that debounces launches into the lowest idle slot, or is dropped.
    function automatic void expect_fire(input logic [7:0] busy);
        fire_ev_t e;
        int slot = -1;
        for (int i = 0; i < 8; i++) if (!busy[i] && slot < 0) slot = i;
        if (slot < 0) begin
            e.dropped = 1'b1;
        end else begin
            model_en[slot] = ~model_en[slot];
            e.dropped = 1'b0;
        end
        e.en = model_en;
        fire_q.push_back(e);
    endfunction

    // A direction held for h raw cycles is accepted 6 cycles late and released
    // 6 cycles late; steps fall every 8 cycles of acceptance.
    function automatic void expect_move(input int hl, input int hr);
        int h;
        int steps;
        int nc;
        if ((hl > 0 && hr > 0) || (hl == 0 && hr == 0)) return;
        h = (hl > 0) ? hl : hr;
        if (h < 8) return;
        steps = (h - 8) / 8 + 1;
        for (int k = 0; k < steps; k++) begin
            if (hr > 0) nc = (model_col + 2 > 624) ? 624 : model_col + 2;
            else        nc = (model_col - 2 < 0) ? 0 : model_col - 2;
            if (nc != model_col) col_q.push_back(nc);
            model_col = nc;
        end
    endfunction

    task automatic run_phase(input int hl, input int hr, input int hf,
                             input logic [7:0] busy, input int tail);
        int n;
        n = hl;
        if (hr > n) n = hr;
        if (hf > n) n = hf;
        expect_move(hl, hr);
        if (hf >= 4) expect_fire(busy);
        missile_busy = busy;
        for (int c = 1; c <= n; c++) begin
            btn_left  = (c <= hl);
            btn_right = (c <= hr);
            btn_fire  = (c <= hf);
            @(negedge clk);
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_fire  = 1'b0;
        repeat (tail) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            last_col = btn_col;
            last_en  = btn_missle_en;
        end else begin
            if (btn_col != last_col) begin
                if (col_q.size() == 0) check("col_unexpected_change", int'(btn_col), int'(last_col));
                else check("col_step", int'(btn_col), col_q.pop_front());
                last_col = btn_col;
            end
            if (fire_pulse || fire_dropped) begin
                check("strobe_exclusive", int'(fire_pulse & fire_dropped), 0);
                if (fire_q.size() == 0) begin
                    check("fire_unexpected", int'({fire_dropped, fire_pulse}), 0);
                end else begin
                    mon_ev = fire_q.pop_front();
                    check("fire_dropped_kind", int'(fire_dropped), int'(mon_ev.dropped));
                    check("fire_en_vector", int'(btn_missle_en), int'(mon_ev.en));
                end
            end else if (btn_missle_en != last_en) begin
                check("en_change_without_pulse", int'(btn_missle_en), int'(last_en));
            end
            last_en = btn_missle_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got t=%0t expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hl, hr, hf, h, kind;
        logic [7:0] busy;

        repeat (3) @(negedge clk);
        #1;
        check("reset_col", int'(btn_col), 312);
        check("reset_en", int'(btn_missle_en), 0);
        check("reset_pulse", int'(fire_pulse), 0);
        check("reset_dropped", int'(fire_dropped), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Right held 100 cycles: 314..336, then no change after release.
        run_phase(0, 100, 0, 8'h00, 40);
        check("col_after_right_100", int'(btn_col), 336);

        // Slots 0 and 2 busy: slot 1 launches.
        run_phase(0, 0, 10, 8'h05, 40);
        check("en_after_busy05", int'(btn_missle_en), 2);

        // All busy: one drop, second press inside cooldown ignored.
        missile_busy = 8'hFF;
        expect_fire(8'hFF);
        for (int c = 0; c < 24; c++) begin
            btn_fire = ((c / 8) % 2 == 0);
            @(negedge clk);
        end
        btn_fire = 1'b0;
        repeat (45) @(negedge clk);

        // Bouncing fire then long hold: exactly one launch.
        missile_busy = 8'h00;
        expect_fire(8'h00);
        for (int c = 0; c < 20; c++) begin
            btn_fire = (c % 4 < 2);
            @(negedge clk);
        end
        btn_fire = 1'b1;
        repeat (200) @(negedge clk);
        btn_fire = 1'b0;
        repeat (45) @(negedge clk);

        // Saturation at both ends.
        run_phase(1500, 0, 0, 8'h00, 40);
        check("col_left_saturated", int'(btn_col), 0);
        run_phase(0, 2600, 0, 8'h00, 40);
        check("col_right_saturated", int'(btn_col), 624);

        // Both held: column holds.
        run_phase(60, 60, 0, 8'h00, 40);
        check("col_both_held", int'(btn_col), 624);

        // Move to 400, launch, then reset mid-cooldown.
        run_phase(896, 0, 0, 8'h00, 40);
        check("col_before_reset", int'(btn_col), 400);
        missile_busy = 8'h00;
        expect_fire(8'h00);
        btn_fire = 1'b1;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        btn_fire = 1'b0;
        @(negedge clk);
        #1;
        check("launch_seen_before_reset", fire_q.size(), 0);
        check("midreset_col", int'(btn_col), 312);
        check("midreset_en", int'(btn_missle_en), 0);
        check("midreset_pulse", int'(fire_pulse), 0);
        model_col = 312;
        model_en  = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_phase(0, 0, 10, 8'h00, 40);
        check("fresh_launch_en", int'(btn_missle_en), 1);

        // Random mixed movement and firing.
        for (int p = 0; p < 25; p++) begin
            kind = $urandom_range(0, 3);
            h    = $urandom_range(4, 60);
            hl   = (kind == 0 || kind == 2) ? h : 0;
            hr   = (kind == 1 || kind == 2) ? h : 0;
            hf   = ($urandom_range(0, 1) == 1) ? $urandom_range(6, 40) : 0;
            busy = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            run_phase(hl, hr, hf, busy, 45);
        end

        repeat (20) @(negedge clk);
        check("col_queue_drained", col_q.size(), 0);
        check("fire_queue_drained", fire_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
